// File: rtl/exception_unit.sv
// Writeback-stage exception arbiter: picks one exception or ERET per instruction,
// strobes coprocessor 0, flushes the pipeline for a fixed time, then redirects fetch.
module exception_unit #(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_delay_slot,
    input  logic        wb_adel_i,
    input  logic        wb_ri,
    input  logic        wb_sys,
    input  logic        wb_bp,
    input  logic        wb_ov,
    input  logic        wb_adel_d,
    input  logic        wb_ades_d,
    input  logic [31:0] wb_bad_addr,
    input  logic        wb_eret,
    input  logic        int_counter,
    input  logic        kernel_mode,
    input  logic [31:0] epc_q,
    output logic        e_enter,
    output logic        eret,
    output logic [4:0]  cause,
    output logic [31:0] epc,
    output logic [31:0] bad_va,
    output logic        delay_slot,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    state_t      state;
    logic [3:0]  flush_cnt;

    logic        ri_eff;
    logic        take_exc;
    logic        take_eret;
    logic        accept;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic [31:0] exc_bad_va;

    // An ERET issued from user mode is a privilege violation and is reported as RI.
    assign ri_eff = wb_ri | (wb_eret & ~kernel_mode);

    always_comb begin
        take_exc   = 1'b1;
        exc_code   = CODE_INT;
        exc_epc    = wb_delay_slot ? (wb_pc - 32'd4) : wb_pc;
        exc_bad_va = '0;
        if (int_counter) begin
            exc_code = CODE_INT;
            exc_epc  = wb_pc;
        end else if (wb_adel_i) begin
            exc_code   = CODE_ADEL;
            exc_bad_va = wb_pc;
        end else if (ri_eff) begin
            exc_code = CODE_RI;
        end else if (wb_sys) begin
            exc_code = CODE_SYS;
        end else if (wb_bp) begin
            exc_code = CODE_BP;
        end else if (wb_ov) begin
            exc_code = CODE_OV;
        end else if (wb_adel_d) begin
            exc_code   = CODE_ADEL;
            exc_bad_va = wb_bad_addr;
        end else if (wb_ades_d) begin
            exc_code   = CODE_ADES;
            exc_bad_va = wb_bad_addr;
        end else begin
            take_exc = 1'b0;
        end
        take_eret = ~take_exc & wb_eret & kernel_mode;
    end

    assign accept = (state == ST_IDLE) & wb_valid & (take_exc | take_eret);

    // Sequencer: the event strobe lasts one cycle, FLUSH lasts FLUSH_CYCLES, then one
    // redirect cycle; the cause/EPC fields hold until the next accepted exception.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            flush_cnt   <= '0;
            e_enter     <= 1'b0;
            eret        <= 1'b0;
            cause       <= '0;
            epc         <= '0;
            bad_va      <= '0;
            delay_slot  <= 1'b0;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                        flush     <= 1'b1;
                        busy      <= 1'b1;
                        if (take_exc) begin
                            e_enter     <= 1'b1;
                            cause       <= exc_code;
                            epc         <= exc_epc;
                            bad_va      <= exc_bad_va;
                            delay_slot  <= wb_delay_slot;
                            redirect_pc <= EXC_VECTOR;
                        end else begin
                            eret        <= 1'b1;
                            redirect_pc <= epc_q;
                        end
                    end
                end
                ST_FLUSH: begin
                    e_enter <= 1'b0;
                    eret    <= 1'b0;
                    if (flush_cnt == 4'd0) begin
                        flush    <= 1'b0;
                        redirect <= 1'b1;
                        state    <= ST_REDIRECT;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    redirect <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Coprocessor 0 must never see both strobes together.
    a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n) !(e_enter && eret));

endmodule

// File: tb/tb_exception_unit.sv
// Randomized self-checking bench for exception_unit against a transaction-level
// priority model; includes the directed cases and a mid-sequence reset.
module tb_exception_unit;

    localparam int          FC  = 3;
    localparam logic [31:0] VEC = 32'h0000_0180;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        ds;
        logic        adel_i;
        logic        ri;
        logic        sys;
        logic        bp;
        logic        ov;
        logic        adel_d;
        logic        ades_d;
        logic [31:0] bad;
        logic        eret;
        logic        intr;
        logic        kernel;
        logic [31:0] epcq;
    } stim_t;

    typedef struct {
        int          kind;
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] bad_va;
        logic        ds;
        logic [31:0] target;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid, wb_delay_slot, wb_adel_i, wb_ri, wb_sys, wb_bp, wb_ov;
    logic        wb_adel_d, wb_ades_d, wb_eret, int_counter, kernel_mode;
    logic [31:0] wb_pc, wb_bad_addr, epc_q;
    logic        e_enter, eret, delay_slot, flush, redirect, busy;
    logic [4:0]  cause;
    logic [31:0] epc, bad_va, redirect_pc;

    int checks = 0;
    int fails  = 0;

    logic [4:0]  m_cause;
    logic [31:0] m_epc, m_bad_va, m_rpc;
    logic        m_ds;

    exception_unit #(.FLUSH_CYCLES(FC), .EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_delay_slot(wb_delay_slot),
        .wb_adel_i(wb_adel_i), .wb_ri(wb_ri), .wb_sys(wb_sys), .wb_bp(wb_bp),
        .wb_ov(wb_ov), .wb_adel_d(wb_adel_d), .wb_ades_d(wb_ades_d),
        .wb_bad_addr(wb_bad_addr), .wb_eret(wb_eret), .int_counter(int_counter),
        .kernel_mode(kernel_mode), .epc_q(epc_q),
        .e_enter(e_enter), .eret(eret), .cause(cause), .epc(epc), .bad_va(bad_va),
        .delay_slot(delay_slot), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        wb_valid      = s.valid;
        wb_pc         = s.pc;
        wb_delay_slot = s.ds;
        wb_adel_i     = s.adel_i;
        wb_ri         = s.ri;
        wb_sys        = s.sys;
        wb_bp         = s.bp;
        wb_ov         = s.ov;
        wb_adel_d     = s.adel_d;
        wb_ades_d     = s.ades_d;
        wb_bad_addr   = s.bad;
        wb_eret       = s.eret;
        int_counter   = s.intr;
        kernel_mode   = s.kernel;
        epc_q         = s.epcq;
    endtask

    function automatic stim_t bubble();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t randomStim();
        stim_t s;
        s.valid  = ($urandom_range(7) != 0);
        s.pc     = $urandom & 32'hFFFF_FFFC;
        s.ds     = 1'($urandom_range(1));
        s.adel_i = ($urandom_range(5) == 0);
        s.ri     = ($urandom_range(5) == 0);
        s.sys    = ($urandom_range(5) == 0);
        s.bp     = ($urandom_range(5) == 0);
        s.ov     = ($urandom_range(5) == 0);
        s.adel_d = ($urandom_range(5) == 0);
        s.ades_d = ($urandom_range(5) == 0);
        s.bad    = $urandom;
        s.eret   = ($urandom_range(4) == 0);
        s.intr   = ($urandom_range(7) == 0);
        s.kernel = 1'($urandom_range(1));
        s.epcq   = $urandom;
        return s;
    endfunction

    // Reference: walk the priority table and return the first hit; kind 0 none, 1 exception, 2 ERET.
    function automatic expect_t predict(input stim_t s);
        expect_t e;
        bit      hit[8];
        int      codes[8] = '{0, 4, 10, 8, 9, 12, 4, 5};
        e.kind = 0; e.code = '0; e.epc = '0; e.bad_va = '0; e.ds = 1'b0; e.target = '0;
        if (!s.valid) return e;
        hit = '{s.intr, s.adel_i, s.ri | (s.eret & ~s.kernel), s.sys, s.bp, s.ov, s.adel_d, s.ades_d};
        for (int i = 0; i < 8; i++) begin
            if (hit[i]) begin
                e.kind   = 1;
                e.code   = 5'(codes[i]);
                e.epc    = (i == 0) ? s.pc : (s.ds ? s.pc - 32'd4 : s.pc);
                e.bad_va = (i == 1) ? s.pc : ((i >= 6) ? s.bad : 32'd0);
                e.ds     = s.ds;
                e.target = VEC;
                return e;
            end
        end
        if (s.eret && s.kernel) begin
            e.kind   = 2;
            e.target = s.epcq;
        end
        return e;
    endfunction

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_cause"}, 32'(cause), 32'(m_cause));
        checkOutput({tag, "_epc"}, epc, m_epc);
        checkOutput({tag, "_bad_va"}, bad_va, m_bad_va);
        checkOutput({tag, "_ds"}, 32'(delay_slot), 32'(m_ds));
        checkOutput({tag, "_rpc"}, redirect_pc, m_rpc);
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic runTransaction(input stim_t s);
        expect_t e;
        e = predict(s);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        applyStimulus(s);
        @(posedge clk); #1;
        if (e.kind == 0) begin
            applyStimulus(bubble());
            checkOutput("none_busy", 32'(busy), 32'd0);
            checkOutput("none_flush", 32'(flush), 32'd0);
            checkOutput("none_eenter", 32'(e_enter), 32'd0);
            checkOutput("none_eret", 32'(eret), 32'd0);
            checkOutput("none_redirect", 32'(redirect), 32'd0);
            checkHeld("none");
            return;
        end
        applyStimulus(randomStim());
        if (e.kind == 1) begin
            m_cause = e.code; m_epc = e.epc; m_bad_va = e.bad_va; m_ds = e.ds;
        end
        m_rpc = e.target;
        checkOutput("ev_eenter", 32'(e_enter), 32'(e.kind == 1));
        checkOutput("ev_eret", 32'(eret), 32'(e.kind == 2));
        checkOutput("ev_flush", 32'(flush), 32'd1);
        checkOutput("ev_busy", 32'(busy), 32'd1);
        checkOutput("ev_redirect", 32'(redirect), 32'd0);
        checkHeld("ev");
        for (int k = 2; k <= FC; k++) begin
            @(posedge clk); #1;
            applyStimulus(randomStim());
            checkOutput("fl_flush", 32'(flush), 32'd1);
            checkOutput("fl_busy", 32'(busy), 32'd1);
            checkOutput("fl_strobes", {30'd0, e_enter, eret}, 32'd0);
            checkOutput("fl_redirect", 32'(redirect), 32'd0);
        end
        @(posedge clk); #1;
        checkOutput("rd_redirect", 32'(redirect), 32'd1);
        checkOutput("rd_flush", 32'(flush), 32'd0);
        checkOutput("rd_busy", 32'(busy), 32'd1);
        checkOutput("rd_strobes", {30'd0, e_enter, eret}, 32'd0);
        checkHeld("rd");
        @(posedge clk); #1;
        applyStimulus(bubble());
        checkOutput("back_redirect", 32'(redirect), 32'd0);
    endtask

    task automatic resetMidTest();
        stim_t s;
        s = bubble();
        s.valid = 1'b1; s.ov = 1'b1; s.pc = 32'h0000_0500;
        applyStimulus(s);
        @(posedge clk); #1;
        checkOutput("rst_first_eenter", 32'(e_enter), 32'd1);
        s = bubble();
        s.valid = 1'b1; s.sys = 1'b1; s.pc = 32'h0000_0600;
        applyStimulus(s);
        @(posedge clk); #1;
        applyStimulus(bubble());
        checkOutput("rst_no_second_eenter", 32'(e_enter), 32'd0);
        checkOutput("rst_cause_kept", 32'(cause), 32'd12);
        rst_n = 1'b0;
        #1;
        m_cause = '0; m_epc = '0; m_bad_va = '0; m_ds = 1'b0; m_rpc = '0;
        checkOutput("rst_flush", 32'(flush), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_redirect", 32'(redirect), 32'd0);
        checkHeld("rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < FC + 3; k++) begin
            @(posedge clk); #1;
            checkOutput("post_rst_redirect", 32'(redirect), 32'd0);
            checkOutput("post_rst_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        stim_t s;
        applyStimulus(bubble());
        m_cause = '0; m_epc = '0; m_bad_va = '0; m_ds = 1'b0; m_rpc = '0;
        #12;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_flush", 32'(flush), 32'd0);
        checkOutput("reset_strobes", {29'd0, e_enter, eret, redirect}, 32'd0);
        checkHeld("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        s = bubble(); s.valid = 1; s.ov = 1; s.pc = 32'h100;
        runTransaction(s);
        s = bubble(); s.valid = 1; s.ades_d = 1; s.ds = 1; s.pc = 32'h204; s.bad = 32'h1003;
        runTransaction(s);
        s = bubble(); s.valid = 1; s.intr = 1; s.sys = 1; s.pc = 32'h40;
        runTransaction(s);
        s = bubble(); s.valid = 1; s.ri = 1; s.ov = 1; s.pc = 32'h44;
        runTransaction(s);
        s = bubble(); s.valid = 1; s.eret = 1; s.kernel = 1; s.epcq = 32'h3C;
        runTransaction(s);
        s = bubble(); s.valid = 1; s.eret = 1; s.kernel = 0; s.pc = 32'h48; s.epcq = 32'h3C;
        runTransaction(s);
        s = bubble(); s.valid = 0; s.sys = 1; s.pc = 32'h4C;
        runTransaction(s);
        s = bubble(); s.valid = 1; s.adel_i = 1; s.pc = 32'h3001; s.bad = 32'h77;
        runTransaction(s);
        s = bubble(); s.valid = 1; s.sys = 1; s.ds = 1; s.pc = 32'h0;
        runTransaction(s);
        s = bubble(); s.valid = 1; s.intr = 1; s.ds = 1; s.pc = 32'h88;
        runTransaction(s);

        resetMidTest();

        for (int n = 0; n < 200; n++) begin
            runTransaction(randomStim());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
